// File: rtl/mono_pkg.sv
// Shared definitions for the MONOPIX readout transmitter emulator: hit word layout
// and transmitter FSM encoding.
package mono_pkg;

  localparam int unsigned MONO_HIT_BITS = 27;

  // Hit word fields: {COL, ROW, LE, TE}
  localparam int unsigned COL_LSB = 21;
  localparam int unsigned COL_W   = 6;
  localparam int unsigned ROW_LSB = 12;
  localparam int unsigned ROW_W   = 9;
  localparam int unsigned LE_LSB  = 6;
  localparam int unsigned LE_W    = 6;
  localparam int unsigned TE_LSB  = 0;
  localparam int unsigned TE_W    = 6;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitRd,
    StShift
  } tx_state_e;

  // Assemble a hit word from its fields.
  function automatic logic [MONO_HIT_BITS-1:0] mono_hit_pack(input logic [COL_W-1:0] col,
                                                             input logic [ROW_W-1:0] row,
                                                             input logic [LE_W-1:0]  le,
                                                             input logic [TE_W-1:0]  te);
    logic [MONO_HIT_BITS-1:0] w;
    w = '0;
    w[COL_LSB +: COL_W] = col;
    w[ROW_LSB +: ROW_W] = row;
    w[LE_LSB +: LE_W]   = le;
    w[TE_LSB +: TE_W]   = te;
    return w;
  endfunction

endpackage

// File: rtl/mono_hit_fifo.sv
// Synchronous hit buffer with first-word-fall-through head, occupancy count and flags.
module mono_hit_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 27
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mono_data_tx_emu.sv
// MONOPIX column readout transmitter emulator: buffers hits, raises TOKEN and shifts one
// hit word MSB-first on DATA per READ strobe, honouring the receiver's FREEZE snapshot.
module mono_data_tx_emu
  import mono_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned HIT_BITS = MONO_HIT_BITS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                HIT_WRITE,
  input  logic [HIT_BITS-1:0] HIT_DATA,
  output logic                HIT_FULL,
  input  logic                FREEZE,
  input  logic                READ,
  output logic                TOKEN,
  output logic                DATA,
  output logic [7:0]          LOST_CNT,
  output logic                READ_ERR
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned BitW = $clog2(HIT_BITS);

  logic [HIT_BITS-1:0] head;
  logic [CntW-1:0]     count, count_nxt;
  logic                full, empty;
  logic                push, pop;

  logic                read_q, freeze_q;
  logic                read_rise, freeze_rise;
  logic                hit_avail;

  tx_state_e           state_q, state_d;
  logic                read_err_q, read_err_d;
  logic [CntW-1:0]     frz_cnt_q, frz_cnt_d;
  logic                token_q, token_d;
  logic [7:0]          lost_q, lost_d;
  logic [HIT_BITS-1:0] shreg_q;
  logic [BitW-1:0]     bitcnt_q;
  logic                data_q;

  assign push = HIT_WRITE & ~full;
  assign pop  = (state_q == StLoad);

  mono_hit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (HIT_BITS)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (HIT_DATA),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign count_nxt   = count + CntW'(push) - CntW'(pop);
  assign read_rise   = READ & ~read_q;
  assign freeze_rise = FREEZE & ~freeze_q;
  // While frozen only the snapshot may be read out; later writes wait for release.
  assign hit_avail   = FREEZE ? (frz_cnt_q != '0) : ~empty;

  // Previous-cycle copies of READ and FREEZE for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      read_q   <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      read_q   <= READ;
      freeze_q <= FREEZE;
    end
  end

  // Transmitter FSM next state and READ_ERR detection.
  always_comb begin
    state_d    = state_q;
    read_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (read_rise) begin
          if (hit_avail) begin
            state_d = StLoad;
          end else begin
            read_err_d = 1'b1;
          end
        end
      end
      StLoad:   state_d = StWaitRd;
      StWaitRd: begin
        if (!READ) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (read_rise) begin
          read_err_d = 1'b1;
        end
        if (bitcnt_q == '0) begin
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // FSM state and error pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      read_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_err_q <= read_err_d;
    end
  end

  // Freeze snapshot, TOKEN and lost-hit counter next state.
  always_comb begin
    frz_cnt_d = frz_cnt_q;
    if (!FREEZE) begin
      frz_cnt_d = '0;
    end else if (freeze_rise) begin
      frz_cnt_d = count - CntW'(pop);
    end else if (pop && frz_cnt_q != '0) begin
      frz_cnt_d = frz_cnt_q - CntW'(1);
    end

    // Looking at next-state values makes TOKEN drop in the LOAD of the last frozen hit.
    token_d = FREEZE ? (frz_cnt_d != '0) : (count_nxt != '0);

    lost_d = lost_q;
    if (HIT_WRITE && full && lost_q != 8'hFF) begin
      lost_d = lost_q + 8'd1;
    end
  end

  // Freeze snapshot, TOKEN and lost-hit counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frz_cnt_q <= '0;
      token_q   <= 1'b0;
      lost_q    <= '0;
    end else begin
      frz_cnt_q <= frz_cnt_d;
      token_q   <= token_d;
      lost_q    <= lost_d;
    end
  end

  // Shift register: load the head word, hold bit 26 until READ falls, then shift out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      data_q   <= 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          shreg_q <= head;
          data_q  <= head[HIT_BITS-1];
        end
        StWaitRd: begin
          bitcnt_q <= BitW'(HIT_BITS - 1);
        end
        StShift: begin
          if (bitcnt_q == '0) begin
            data_q <= 1'b0;
          end else begin
            data_q   <= shreg_q[HIT_BITS-2];
            shreg_q  <= shreg_q << 1;
            bitcnt_q <= bitcnt_q - BitW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign HIT_FULL = full;
  assign TOKEN    = token_q;
  assign DATA     = data_q;
  assign LOST_CNT = lost_q;
  assign READ_ERR = read_err_q;

endmodule
